cipher_uut_sequencer: RTL

//  Parametrised controller between the SD-card autotest logic and a block-cipher UUT (PRESENT-80/128 or similar).

---
 rtl/cipher_seq_pkg.sv | 22 ++
 rtl/cipher_uut_sequencer_sat_counter.sv | 35 +++
 rtl/cipher_uut_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cipher_seq_pkg.sv
// Shared types and constants for the block-cipher UUT sequencer:
// command modes, controller states and the encrypt/decrypt polarity.
package cipher_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ENC       = 2'd0,
        MODE_DEC       = 2'd1,
        MODE_ROUNDTRIP = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE_RST = 3'd1,
        S_RUN     = 3'd2,
        S_CHECK   = 3'd3,
        S_REPORT  = 3'd4
    } state_t;

    localparam logic ENCDEC_ENC = 1'b0;
    localparam logic ENCDEC_DEC = 1'b1;

endpackage

// File: rtl/cipher_uut_sequencer_sat_counter.sv
// Saturating latency counter with synchronous clear and a terminal-count
// flag raised when the count equals TIMEOUT_CYC.
module sat_counter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_term
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_count;

    // Count up while enabled, holding at the all-ones value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == CNT_TERM);

endmodule

// File: rtl/cipher_uut_sequencer.sv
// Runs one test vector per command through a block-cipher UUT, measures
// latency, checks the output and returns a registered result record.
module cipher_uut_sequencer
    import cipher_seq_pkg::*;
#(
    parameter int BLOCK_W     = 64,
    parameter int KEY_W       = 80,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int RST_CYC     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [BLOCK_W-1:0] cmd_block,
    input  logic [KEY_W-1:0]   cmd_key,
    input  logic [BLOCK_W-1:0] cmd_expected,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_pass,
    output logic               res_timeout,
    output logic [CNT_W-1:0]   res_cycles,
    output logic [CNT_W-1:0]   res_cycles2,
    output logic [BLOCK_W-1:0] res_block,
    output logic               rst_uut,
    output logic               clk_en_uut,
    output logic [BLOCK_W-1:0] block_i_uut,
    output logic [KEY_W-1:0]   key_uut,
    output logic               encdec_uut,
    input  logic [BLOCK_W-1:0] block_o_uut,
    input  logic               end_uut
);

    localparam int               PRE_W    = $clog2(RST_CYC + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RST_CYC - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic               r_cmd_ready;
    logic               r_res_valid;
    logic               r_rst_uut;
    logic               r_clk_en;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic [1:0]         r_mode;
    logic [BLOCK_W-1:0] r_cmd_block;
    logic [BLOCK_W-1:0] r_expected;
    logic [BLOCK_W-1:0] r_block_i;
    logic [BLOCK_W-1:0] r_capture;
    logic [KEY_W-1:0]   r_key;
    logic               r_encdec;
    logic               r_second;
    logic               r_pass;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   r_cycles2;

    logic               w_accept;
    logic               w_end;
    logic               w_last_pre;
    logic               w_go_dec;
    logic [BLOCK_W-1:0] w_ref;
    logic               w_match;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic [CNT_W-1:0]   w_count;
    logic               w_term;

    assign w_accept   = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
    assign w_end      = end_uut && r_clk_en;
    assign w_last_pre = (r_pre_cnt == PRE_LAST);
    assign w_go_dec   = (r_mode == MODE_ROUNDTRIP) && !r_second;
    // The decrypt leg of a round trip must reproduce the original plaintext
    assign w_ref      = r_second ? r_cmd_block : r_expected;
    assign w_match    = (r_capture == w_ref);
    assign w_cnt_clr  = (r_state != S_RUN);
    assign w_cnt_en   = (r_state == S_RUN) && !w_end && !w_term;

    sat_counter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_lat_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_term  (w_term)
    );

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_PRE_RST;
                else          w_next = S_IDLE;
            end
            S_PRE_RST: begin
                if (w_last_pre) w_next = S_RUN;
                else            w_next = S_PRE_RST;
            end
            S_RUN: begin
                if (w_end)       w_next = S_CHECK;
                else if (w_term) w_next = S_REPORT;
                else             w_next = S_RUN;
            end
            S_CHECK: begin
                if (w_go_dec) w_next = S_PRE_RST;
                else          w_next = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready) w_next = S_IDLE;
                else           w_next = S_REPORT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; control outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_rst_uut   <= 1'b1;
            r_clk_en    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_res_valid <= (w_next == S_REPORT);
            r_rst_uut   <= (w_next == S_IDLE) || (w_next == S_PRE_RST);
            r_clk_en    <= (w_next == S_PRE_RST) || (w_next == S_RUN);
        end
    end

    // UUT reset-hold cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre_cnt <= '0;
        end else if (r_state == S_PRE_RST) begin
            r_pre_cnt <= r_pre_cnt + PRE_ONE;
        end else begin
            r_pre_cnt <= '0;
        end
    end

    // Command latch, UUT stimulus, capture and result accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode      <= 2'd0;
            r_cmd_block <= '0;
            r_expected  <= '0;
            r_block_i   <= '0;
            r_key       <= '0;
            r_encdec    <= ENCDEC_ENC;
            r_second    <= 1'b0;
            r_capture   <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cycles    <= '0;
            r_cycles2   <= '0;
        end else if (w_accept) begin
            r_mode      <= cmd_mode;
            r_cmd_block <= cmd_block;
            r_expected  <= cmd_expected;
            r_block_i   <= cmd_block;
            r_key       <= cmd_key;
            r_encdec    <= (cmd_mode == MODE_DEC) ? ENCDEC_DEC : ENCDEC_ENC;
            r_second    <= 1'b0;
            r_capture   <= '0;
            r_pass      <= 1'b1;
            r_timeout   <= 1'b0;
            r_cycles    <= '0;
            r_cycles2   <= '0;
        end else if ((r_state == S_RUN) && w_end) begin
            r_capture <= block_o_uut;
            if (r_second) r_cycles2 <= w_count;
            else          r_cycles  <= w_count;
        end else if ((r_state == S_RUN) && w_term) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            if (r_second) r_cycles2 <= w_count;
            else          r_cycles  <= w_count;
        end else if (r_state == S_CHECK) begin
            r_pass <= r_pass && w_match;
            if (w_go_dec) begin
                r_block_i <= r_capture;
                r_encdec  <= ENCDEC_DEC;
                r_second  <= 1'b1;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign res_valid   = r_res_valid;
    assign res_pass    = r_pass;
    assign res_timeout = r_timeout;
    assign res_cycles  = r_cycles;
    assign res_cycles2 = r_cycles2;
    assign res_block   = r_capture;
    assign rst_uut     = r_rst_uut;
    assign clk_en_uut  = r_clk_en;
    assign block_i_uut = r_block_i;
    assign key_uut     = r_key;
    assign encdec_uut  = r_encdec;

endmodule
